// File: rtl/store_buffer_ctrl_pkg.sv
// Shared types for the posted-store buffer: store-type codes, FSM encoding,
// queue entry layout and the byte-lane formatting helper.
package store_buffer_ctrl_pkg;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    // Word-address field is sized for the widest supported (32-bit) address.
    localparam int WADDR_W = 30;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] waddr;
        logic [1:0]         offs;
        logic [1:0]         stype;
        logic [31:0]        data;
    } sb_entry_t;

    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  be;
    } sb_beat_t;

    function automatic sb_beat_t sb_format(input sb_entry_t e);
        sb_beat_t b;
        case (e.stype)
            ST_SB: begin
                b.wdata = {4{e.data[7:0]}};
                b.be    = 4'b0001 << e.offs;
            end
            ST_SH: begin
                b.wdata = {2{e.data[15:0]}};
                b.be    = e.offs[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                b.wdata = e.data;
                b.be    = 4'b1111;
            end
        endcase
        return b;
    endfunction

    function automatic logic sb_misaligned(input logic [1:0] t, input logic [1:0] offs);
        return (t == 2'b11) || ((t == ST_SH) && offs[0]) || ((t == ST_SW) && (offs != 2'b00));
    endfunction

endpackage

// File: rtl/store_buffer_ctrl_if.sv
// Pipeline-side and memory-side signals of the store buffer, grouped so the
// buffer (slave) and its environment (master) see opposite directions.
interface store_buffer_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) ();
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              st_valid;
    logic              st_ready;
    logic [1:0]        st_type;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic              misalign_err;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hazard;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              buf_empty;
    logic [CNT_W-1:0]  buf_count;

    modport slave (
        input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, misalign_err, ld_hazard, mem_req, mem_addr, mem_wdata,
               mem_be, buf_empty, buf_count
    );

    modport master (
        output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, misalign_err, ld_hazard, mem_req, mem_addr, mem_wdata,
               mem_be, buf_empty, buf_count
    );
endinterface

// File: rtl/store_buffer_ctrl_fifo.sv
// Synchronous FIFO of queued stores; also exposes every slot's word address
// and valid bit so the top level can compare loads against pending stores.
module store_buf_fifo
    import store_buffer_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  sb_entry_t          i_entry,
    input  logic               i_pop,
    output sb_entry_t          o_head,
    output sb_entry_t          o_next,
    output logic [CNT_W-1:0]   o_count,
    output logic               o_full,
    output logic               o_empty,
    output logic [WADDR_W-1:0] o_waddr [DEPTH],
    output logic [DEPTH-1:0]   o_valid
);
    sb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [DEPTH-1:0] r_valid;
    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_nxt;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;
    assign w_rd_nxt = r_rd_ptr + PTR_W'(1);
    assign o_head   = r_mem[r_rd_ptr];
    assign o_next   = r_mem[w_rd_nxt];
    assign o_count  = r_count;
    assign o_valid  = r_valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_waddr[i] = r_mem[i].waddr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // Push and pop never touch the same slot: that would need full and empty at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
                r_valid[r_wr_ptr] <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr          <= w_rd_nxt;
                r_valid[r_rd_ptr] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer: checks alignment, queues stores, drains them to memory
// over req/ack with formatted lanes, and flags loads that hit a queued store.
//   state | meaning
//   IDLE  | no write presented, waiting for a queued store
//   REQ   | head store presented on mem_*, waiting for mem_ack
module store_buffer_ctrl
    import store_buffer_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    store_buffer_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_state_e          r_state;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_be;
    logic               r_misalign;

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_accept;
    logic               w_err;
    logic               w_push;
    logic               w_pop;
    logic               w_more;
    logic               w_hit;
    logic               w_unused;
    sb_entry_t          w_entry;
    sb_entry_t          w_head;
    sb_entry_t          w_fifo_next;
    sb_entry_t          w_next;
    sb_beat_t           w_head_beat;
    sb_beat_t           w_next_beat;
    logic [WADDR_W-1:0] w_waddr [DEPTH];
    logic [DEPTH-1:0]   w_valid;
    logic [WADDR_W-1:0] w_ld_waddr;

    assign w_accept = bus.st_valid && !w_full;
    assign w_err    = sb_misaligned(bus.st_type, bus.st_addr[1:0]);
    assign w_push   = w_accept && !w_err;
    assign w_pop    = (r_state == REQ) && bus.mem_ack;

    assign w_entry.waddr = WADDR_W'(bus.st_addr[ADDR_W-1:2]);
    assign w_entry.offs  = bus.st_addr[1:0];
    assign w_entry.stype = bus.st_type;
    assign w_entry.data  = bus.st_data;

    store_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_next  (w_fifo_next),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_waddr (w_waddr),
        .o_valid (w_valid)
    );

    // With a single entry left, the successor is whatever is being pushed now.
    assign w_more      = (w_count > CNT_W'(1)) || w_push;
    assign w_next      = (w_count > CNT_W'(1)) ? w_fifo_next : w_entry;
    assign w_head_beat = sb_format(w_head);
    assign w_next_beat = sb_format(w_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_misalign <= w_accept && w_err;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state     <= REQ;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= {w_head.waddr[ADDR_W-3:0], 2'b00};
                        r_mem_wdata <= w_head_beat.wdata;
                        r_mem_be    <= w_head_beat.be;
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        if (w_more) begin
                            r_mem_addr  <= {w_next.waddr[ADDR_W-3:0], 2'b00};
                            r_mem_wdata <= w_next_beat.wdata;
                            r_mem_be    <= w_next_beat.be;
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign w_ld_waddr = WADDR_W'(bus.ld_addr[ADDR_W-1:2]);
    assign w_unused   = &{1'b0, bus.ld_addr[1:0]};

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i] && (w_waddr[i] == w_ld_waddr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign bus.st_ready     = !w_full;
    assign bus.misalign_err = r_misalign;
    assign bus.ld_hazard    = bus.ld_valid && w_hit;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_be       = r_mem_be;
    assign bus.buf_empty    = w_empty;
    assign bus.buf_count    = w_count;
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Scoreboard bench for store_buffer_ctrl: directed stores push expected memory
// beats into a queue; a negedge monitor pops and compares each acked write.
module tb_store_buffer_ctrl;
    logic clk;
    logic rst;

    store_buffer_ctrl_if #(.ADDR_W(32), .DEPTH(4)) bus ();

    store_buffer_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    seen_pulses = 0;
    int    exp_pulses = 0;
    logic  prev_mis = 1'b0;
    logic  req_seen = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req) req_seen = 1'b1;
            if (bus.misalign_err) begin
                seen_pulses++;
                check("mis_one_cycle", {31'b0, prev_mis}, 32'd0);
            end
            prev_mis = bus.misalign_err;
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%08h, expected no write", bus.mem_addr);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, e.addr);
                    check("wr_data", bus.mem_wdata, e.wdata);
                    check("wr_be", {28'b0, bus.mem_be}, {28'b0, e.be});
                end
            end
        end
    end

    task automatic push_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ea, input logic [31:0] ew, input logic [3:0] ebe,
                              input bit is_err);
        int n = 0;
        bus.st_valid = 1'b1;
        bus.st_type  = t;
        bus.st_addr  = a;
        bus.st_data  = d;
        @(negedge clk);
        while (!bus.st_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got st_ready=0 for 200 cycles, expected acceptance");
        end else begin
            @(posedge clk);
            if (is_err) exp_pulses++;
            else exp_q.push_back('{addr: ea, wdata: ew, be: ebe});
        end
        #1;
        bus.st_valid = 1'b0;
    endtask

    task automatic wait_empty(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.buf_empty && n < 100);
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got buf_empty=0 after 100 cycles, expected 1");
        end
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_type  = 2'b00;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.mem_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        check("rst_empty", {31'b0, bus.buf_empty}, 32'd1);
        check("rst_count", {29'b0, bus.buf_count}, 32'd0);
        check("rst_mis", {31'b0, bus.misalign_err}, 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_be", {28'b0, bus.mem_be}, 32'd0);
        check("rst_ready", {31'b0, bus.st_ready}, 32'd1);

        // Single word store, ack tied high.
        bus.mem_ack = 1'b1;
        push_store(2'b10, 32'h100, 32'hDEADBEEF, 32'h100, 32'hDEADBEEF, 4'b1111, 0);
        check("lat_req_n", {31'b0, bus.mem_req}, 32'd0);
        check("lat_count", {29'b0, bus.buf_count}, 32'd1);
        @(posedge clk); #1;
        check("lat_req_n1", {31'b0, bus.mem_req}, 32'd1);
        @(posedge clk); #1;
        check("sw_empty", {31'b0, bus.buf_empty}, 32'd1);
        check("sw_req_drop", {31'b0, bus.mem_req}, 32'd0);

        // Byte and halfword formatting, back to back.
        push_store(2'b00, 32'h203, 32'h000000A5, 32'h200, 32'hA5A5A5A5, 4'b1000, 0);
        push_store(2'b01, 32'h302, 32'h00001234, 32'h300, 32'h12341234, 4'b1100, 0);
        wait_empty(n);

        // Fill with ack held low, then release and drain.
        bus.mem_ack = 1'b0;
        push_store(2'b10, 32'h500, 32'h11111111, 32'h500, 32'h11111111, 4'b1111, 0);
        push_store(2'b00, 32'h505, 32'h000000C3, 32'h504, 32'hC3C3C3C3, 4'b0010, 0);
        push_store(2'b01, 32'h508, 32'h0000BEEF, 32'h508, 32'hBEEFBEEF, 4'b0011, 0);
        push_store(2'b10, 32'h50C, 32'h44444444, 32'h50C, 32'h44444444, 4'b1111, 0);
        check("full_ready", {31'b0, bus.st_ready}, 32'd0);
        check("full_count", {29'b0, bus.buf_count}, 32'd4);
        fork
            push_store(2'b10, 32'h510, 32'h55555555, 32'h510, 32'h55555555, 4'b1111, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("full_hold_count", {29'b0, bus.buf_count}, 32'd4);
                check("full_hold_ready", {31'b0, bus.st_ready}, 32'd0);
                bus.mem_ack = 1'b1;
                wait_empty(n);
                check("drain_cycles", n, 32'd5);
            end
        join

        // Misaligned and illegal stores are dropped with a one-cycle pulse.
        req_seen = 1'b0;
        push_store(2'b10, 32'h101, 32'h0, 32'h0, 32'h0, 4'h0, 1);
        check("mis_sw", {31'b0, bus.misalign_err}, 32'd1);
        check("mis_sw_cnt", {29'b0, bus.buf_count}, 32'd0);
        @(posedge clk); #1;
        check("mis_sw_clr", {31'b0, bus.misalign_err}, 32'd0);
        push_store(2'b01, 32'h41, 32'h0, 32'h0, 32'h0, 4'h0, 1);
        check("mis_sh", {31'b0, bus.misalign_err}, 32'd1);
        check("mis_sh_cnt", {29'b0, bus.buf_count}, 32'd0);
        @(posedge clk); #1;
        check("mis_sh_clr", {31'b0, bus.misalign_err}, 32'd0);
        push_store(2'b11, 32'h200, 32'h0, 32'h0, 32'h0, 4'h0, 1);
        check("mis_ill", {31'b0, bus.misalign_err}, 32'd1);
        check("mis_ill_cnt", {29'b0, bus.buf_count}, 32'd0);
        @(posedge clk); #1;
        check("mis_ill_clr", {31'b0, bus.misalign_err}, 32'd0);
        repeat (3) @(posedge clk); #1;
        check("mis_no_req", {31'b0, req_seen}, 32'd0);

        // Load hazard against a pending byte store.
        bus.mem_ack = 1'b0;
        push_store(2'b00, 32'h400, 32'h00000077, 32'h400, 32'h77777777, 4'b0001, 0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h402;
        #1 check("hz_hit", {31'b0, bus.ld_hazard}, 32'd1);
        bus.ld_addr  = 32'h404;
        #1 check("hz_miss", {31'b0, bus.ld_hazard}, 32'd0);
        bus.ld_valid = 1'b0;
        bus.ld_addr  = 32'h400;
        #1 check("hz_noload", {31'b0, bus.ld_hazard}, 32'd0);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 32'h402;
        @(posedge clk); #1;
        check("hz_inflight", {31'b0, bus.ld_hazard}, 32'd1);
        bus.mem_ack = 1'b1;
        wait_empty(n);
        check("hz_after_ack", {31'b0, bus.ld_hazard}, 32'd0);
        bus.ld_valid = 1'b0;

        // Asynchronous reset in the middle of a request.
        bus.mem_ack = 1'b0;
        push_store(2'b10, 32'h600, 32'h60606060, 32'h600, 32'h60606060, 4'b1111, 0);
        push_store(2'b10, 32'h604, 32'h61616161, 32'h604, 32'h61616161, 4'b1111, 0);
        push_store(2'b10, 32'h608, 32'h62626262, 32'h608, 32'h62626262, 4'b1111, 0);
        check("prerst_req", {31'b0, bus.mem_req}, 32'd1);
        check("prerst_count", {29'b0, bus.buf_count}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("arst_req", {31'b0, bus.mem_req}, 32'd0);
        check("arst_count", {29'b0, bus.buf_count}, 32'd0);
        check("arst_empty", {31'b0, bus.buf_empty}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Buffer is usable again after reset.
        bus.mem_ack = 1'b1;
        push_store(2'b01, 32'h702, 32'h0000ABCD, 32'h700, 32'hABCDABCD, 4'b1100, 0);
        wait_empty(n);
        repeat (2) @(posedge clk); #1;

        check("sb_drained", exp_q.size(), 32'd0);
        check("mis_pulses", seen_pulses, exp_pulses);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected earlier finish");
        $fatal(1);
    end
endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
Posted-store buffer between the execute stage and the data memory port. It accepts SB/SH/SW requests from the pipeline and queues them in a small FIFO. It drains the queue to memory over a req/ack handshake, generating the byte lanes and replicated write data for each store. It also flags loads that hit a pending store, so the pipeline can stall them.

Parameters:
DEPTH, 4, number of queued stores (power of two, 2..16)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
st_valid  in  1  store request from execute stage
st_ready  out  1  buffer can accept a store this cycle
st_type  in  2  00=SB, 01=SH, 10=SW, 11=illegal
st_addr  in  ADDR_W  byte address (ALU result)
st_data  in  32  rs2 data
misalign_err  out  1  one-cycle pulse: accepted store was misaligned or illegal and was dropped
ld_valid  in  1  load in execute stage
ld_addr  in  ADDR_W  load byte address
ld_hazard  out  1  load word matches a pending store (combinational)
mem_req  out  1  memory write request
mem_ack  in  1  memory accepted current write
mem_addr  out  ADDR_W  word-aligned address, [1:0]=00
mem_wdata  out  32  formatted write data
mem_be  out  4  byte enables
buf_empty  out  1  no pending stores
buf_count  out  $clog2(DEPTH+1)  number of pending stores

Behaviour:
- Reset (async, rst=1): FIFO pointers and count are cleared; mem_req=0, misalign_err=0, buf_empty=1, buf_count=0, FSM=IDLE. mem_addr, mem_wdata and mem_be are 0. Reset mid-transaction abandons the in-flight write; mem_req drops immediately.
- Accept: a store is accepted when st_valid && st_ready.
  - st_ready = (buf_count < DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Alignment check at accept:
  - SH with addr[0]=1, SW with addr[1:0]!=00, and type 11 are all errors.
  - An error store is not enqueued. misalign_err=1 on the following cycle, for exactly one cycle.
- Each entry stores word address addr[ADDR_W-1:2], addr[1:0], type and data.
- Formatting, applied to the head entry:
  - SB: wdata = byte replicated x4; be = 0001 << addr[1:0].
  - SH: wdata = halfword replicated x2; be = addr[1] ? 1100 : 0011.
  - SW: wdata = data; be = 1111.
- FSM states:
  - IDLE: mem_req=0. Moves to REQ when the FIFO is non-empty.
  - REQ: mem_req=1. mem_addr, mem_wdata and mem_be are registered from the head entry and stay stable until mem_ack.
    - On mem_ack: pop the head. If entries remain after the pop (including one enqueued the same cycle), stay in REQ and present the next entry the following cycle. Otherwise go to IDLE.
- Latency: a store accepted into an empty buffer at edge N gives mem_req=1 after edge N+1. Back-to-back acks sustain one store per cycle.
- Simultaneous accept and pop: buf_count is unchanged, and both pointers advance.
- ld_hazard = ld_valid && (any valid entry, including the in-flight head, has word address == ld_addr[ADDR_W-1:2]).
  - This is purely combinational and sees the FIFO state before the current edge.
  - A store being accepted in the same cycle is not checked.
- Pointers wrap modulo DEPTH. buf_count never exceeds DEPTH and never underflows; mem_ack while in IDLE is ignored.

Decomposition:
- Shared package holds:
  - store-type constants ST_SB=2'b00, ST_SH=2'b01, ST_SW=2'b10.
  - FSM state encoding (IDLE, REQ).
  - The entry struct: {word addr, offset[1:0], type[1:0], data[31:0]}.
- One sub-module, store_buf_fifo. It is a parameterised synchronous FIFO with push/pop, count, and full/empty. It exposes all entries' word addresses and valid bits for the hazard compare.
- Alignment check, formatting, FSM and hazard compare live in the top level.

Test Plan:
- Reset, then SW addr=0x100 data=0xDEADBEEF with mem_ack tied 1 -> mem_req at edge+1; mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_be=1111; buf_empty=1 after the ack.
- SB addr=0x203 data=0x000000A5, SH addr=0x302 data=0x00001234 -> mem_wdata=0xA5A5A5A5 with be=1000 and mem_addr=0x200; then 0x12341234 with be=1100 and mem_addr=0x300.
- mem_ack held 0, push 5 stores with DEPTH=4 -> st_ready=0 after the 4th; buf_count=4; the 5th waits. Release ack -> stores drain in order, one per cycle, and the 5th is accepted once count<4.
- SW addr=0x101, then SH addr=0x41, then type 11 -> each produces a one-cycle misalign_err pulse; buf_count stays 0; mem_req never rises.
- Pending SB to 0x400 with ack held 0, ld_valid with ld_addr=0x402 -> ld_hazard=1; ld_addr=0x404 -> ld_hazard=0; after the ack -> ld_hazard=0 for 0x402.
- Assert rst while mem_req=1 with 3 entries queued -> mem_req=0, buf_count=0 and buf_empty=1 immediately, without waiting for a clock edge.
